branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 64: number of 2-bit predictor entries, power of two, 2..1024.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port if_valid  input  1  fetch-stage lookup valid.
REQ-005 SHALL have port if_pc  input  32  fetch PC for prediction lookup.
REQ-006 SHALL have port pred_taken  output  1  prediction for if_pc.
REQ-007 SHALL have port ex_valid  input  1  EX-stage instruction valid.
REQ-008 SHALL have port ex_is_branch  input  1  EX instruction is conditional branch.
REQ-009 SHALL have port ex_funct3  input  3  branch funct3.
REQ-010 SHALL have port ex_pc  input  32  PC of EX branch.
REQ-011 SHALL have port ex_target  input  32  computed branch target.
REQ-012 SHALL have port ex_pred_taken  input  1  prediction carried down the pipeline with the branch.
REQ-013 SHALL have port stall  input  1  pipeline stall; blocks resolution and all state updates.
REQ-014 SHALL have port br_un  output  1  unsigned-compare select to bcmp.
REQ-015 SHALL have ports br_eq, br_lt  input  1 each  bcmp results.
REQ-016 SHALL have port redirect  output  1  mispredict; fetch restarts at redirect_pc.
REQ-017 SHALL have port redirect_pc  output  32  corrected next PC.
REQ-018 SHALL have port illegal_br  output  1  funct3 010/011 seen on a resolving branch.
REQ-019 SHALL have port cnt_clr  input  1  synchronous clear of both statistics counters.
REQ-020 SHALL have ports cnt_branches, cnt_mispredict  output  32 each  statistics counters.

Function
REQ-021 SHALL drive br_un = ex_funct3[1], combinationally.
REQ-022 SHALL define resolve = ex_valid & ex_is_branch & !stall.
REQ-023 SHALL compute taken as: 000 eq; 001 !eq; 100 lt; 101 !lt; 110 lt; 111 !lt; 010/011 taken=0 with illegal_br=resolve.
REQ-024 SHALL assert redirect = resolve & (taken != ex_pred_taken) & legal funct3, same cycle (0 latency).
REQ-025 SHALL drive redirect_pc = taken ? ex_target : ex_pc+4 (32-bit wrap; 0xFFFFFFFC+4 = 0).
REQ-026 SHALL index the predictor with pc[log2(BHT_ENTRIES)+1:2]; states SNT=00, WNT=01, WT=10, ST=11.
REQ-027 SHALL drive pred_taken = if_valid & entry[if_pc][1].
REQ-028 SHALL, on resolve with legal funct3, increment the entry at ex_pc (saturating at 11) if taken, else decrement it (saturating at 00), at the next edge.
REQ-029 SHALL return the pre-update value when lookup and update address the same entry in one cycle.
REQ-030 SHALL increment cnt_branches on each resolve with legal funct3, and cnt_mispredict on each redirect; both saturate at 0xFFFFFFFF.
REQ-031 SHALL give cnt_clr priority over a same-cycle increment (result 0).
REQ-032 SHALL not update table or counters while stall=1; outputs derived from the stalled branch remain combinationally valid.

Reset
REQ-033 SHALL on rst clear counters to 0 and set every table entry to WNT, immediately and independent of clk, including mid-operation.
REQ-034 SHALL hold pred_taken=0, redirect=0 and illegal_br=0 while rst=1.

Configuration
REQ-035 SHALL with BRANCH_PREDICT_EN defined, implement the table per REQ-026..029.
REQ-036 SHALL without BRANCH_PREDICT_EN, instantiate no table, tie pred_taken=0, and redirect on every legal taken branch; counters remain.

Structure
REQ-037 SHALL take funct3 branch encodings and state encodings SNT/WNT/WT/ST from shared package riscv_branch_pkg.
REQ-038 SHALL place the table in sub-module bht_2bit (lookup port, update port, async reset).

Verification
REQ-039 SHALL cover: BEQ funct3=000, eq=1, ex_pred_taken=0, target 0x100 -> redirect=1, redirect_pc=0x100, cnt_mispredict=1.
REQ-040 SHALL cover: BGEU funct3=111 -> br_un=1; lt=0, ex_pred_taken=1 -> redirect=0, cnt_branches incremented.
REQ-041 SHALL cover: three taken resolves at pc 0x40 from reset -> entry WNT->WT->ST->ST; lookup of pc 0x40 gives pred_taken=1.
REQ-042 SHALL cover: funct3=010 resolve -> illegal_br=1, redirect=0, counters and table unchanged.
REQ-043 SHALL cover: stall=1 with a valid taken branch -> no counter or table change; rst asserted mid-sequence -> counters=0, pred_taken=0 at once.
REQ-044 SHALL cover: counter preloaded to 0xFFFFFFFF holds on an increment; cnt_clr together with an increment gives 0.

Source files
------------

// File: rtl/riscv_branch_pkg.sv
// Shared RISC-V branch encodings, 2-bit predictor states and small saturating helpers
// used by branch_unit and its predictor table.
package riscv_branch_pkg;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_RSV2 = 3'b010,
      F3_RSV3 = 3'b011,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } br_funct3_e;

   typedef enum logic [1:0] {
      BHT_SNT = 2'b00,
      BHT_WNT = 2'b01,
      BHT_WT  = 2'b10,
      BHT_ST  = 2'b11
   } bht_state_e;

   function automatic bht_state_e bht_next(input bht_state_e cur, input logic taken);
      bht_state_e nxt;
      case (cur)
         BHT_SNT: nxt = taken ? BHT_WNT : BHT_SNT;
         BHT_WNT: nxt = taken ? BHT_WT  : BHT_SNT;
         BHT_WT:  nxt = taken ? BHT_ST  : BHT_WNT;
         BHT_ST:  nxt = taken ? BHT_ST  : BHT_WT;
         default: nxt = BHT_WNT;
      endcase
      return nxt;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Fetch-lookup, EX-resolution, comparator and statistics signals of branch_unit.
interface branch_unit_if;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic        ex_valid;
   logic        ex_is_branch;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic        stall;
   logic        br_un;
   logic        br_eq;
   logic        br_lt;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        illegal_br;
   logic        cnt_clr;
   logic [31:0] cnt_branches;
   logic [31:0] cnt_mispredict;

   modport slave (
      input  if_valid, if_pc, ex_valid, ex_is_branch, ex_funct3, ex_pc, ex_target,
             ex_pred_taken, stall, br_eq, br_lt, cnt_clr,
      output pred_taken, br_un, redirect, redirect_pc, illegal_br, cnt_branches, cnt_mispredict
   );

   modport master (
      output if_valid, if_pc, ex_valid, ex_is_branch, ex_funct3, ex_pc, ex_target,
             ex_pred_taken, stall, br_eq, br_lt, cnt_clr,
      input  pred_taken, br_un, redirect, redirect_pc, illegal_br, cnt_branches, cnt_mispredict
   );
endinterface

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating predictors: combinational lookup port, clocked update port,
// asynchronous reset of every entry to weakly not-taken.
module bht_2bit
   import riscv_branch_pkg::*;
#(
   parameter int ENTRIES = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [$clog2(ENTRIES)-1:0]   lookup_idx,
   output logic                         lookup_taken,
   input  logic                         update_en,
   input  logic [$clog2(ENTRIES)-1:0]   update_idx,
   input  logic                         update_taken
);
   bht_state_e table_r [ENTRIES];
   bht_state_e lookup_state_s;

   // Reading the registers directly gives the pre-update value on a same-entry collision.
   assign lookup_state_s = table_r[lookup_idx];
   assign lookup_taken   = (lookup_state_s == BHT_WT) || (lookup_state_s == BHT_ST);

   // Predictor state update on resolved legal branches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_r[i] <= BHT_WNT;
         end
      end else if (update_en) begin
         table_r[update_idx] <= bht_next(table_r[update_idx], update_taken);
      end
   end
endmodule

// File: rtl/branch_unit.sv
// Branch resolution: condition decode, zero-latency mispredict redirect and statistics.
// Define BRANCH_PREDICT_EN to add the 2-bit predictor table (bht_2bit).
module branch_unit
   import riscv_branch_pkg::*;
#(
   parameter int BHT_ENTRIES = 64
) (
   input logic          clk,
   input logic          rst,
   branch_unit_if.slave bus
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic        resolve_s;
   logic        legal_s;
   logic        taken_s;
   logic        mispredict_s;
   logic        update_s;
   logic        lookup_taken_s;
   logic        unused_s;
   logic [31:0] cnt_branches_r;
   logic [31:0] cnt_mispredict_r;

   // Branch condition from funct3 and the comparator flags; 010/011 are not branches.
   always_comb begin
      taken_s = 1'b0;
      legal_s = 1'b1;
      case (br_funct3_e'(bus.ex_funct3))
         F3_BEQ:          taken_s = bus.br_eq;
         F3_BNE:          taken_s = ~bus.br_eq;
         F3_BLT, F3_BLTU: taken_s = bus.br_lt;
         F3_BGE, F3_BGEU: taken_s = ~bus.br_lt;
         F3_RSV2, F3_RSV3: legal_s = 1'b0;
         default:         legal_s = 1'b0;
      endcase
   end

   assign resolve_s = bus.ex_valid & bus.ex_is_branch & ~bus.stall;
   assign update_s  = resolve_s & legal_s;

`ifdef BRANCH_PREDICT_EN
   bht_2bit #(
      .ENTRIES (BHT_ENTRIES)
   ) u_bht (
      .clk          (clk),
      .rst          (rst),
      .lookup_idx   (bus.if_pc[IDX_W+1:2]),
      .lookup_taken (lookup_taken_s),
      .update_en    (update_s),
      .update_idx   (bus.ex_pc[IDX_W+1:2]),
      .update_taken (taken_s)
   );
   assign mispredict_s = taken_s ^ bus.ex_pred_taken;
   assign unused_s     = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0]};
`else
   // Without a table fetch always falls through, so every taken branch is a mispredict.
   assign lookup_taken_s = 1'b0;
   assign mispredict_s   = taken_s;
   assign unused_s       = ^{bus.if_pc, bus.ex_pred_taken, IDX_W};
`endif

   assign bus.br_un          = bus.ex_funct3[1];
   assign bus.pred_taken     = bus.if_valid & lookup_taken_s & ~rst;
   assign bus.redirect       = update_s & mispredict_s & ~rst;
   assign bus.illegal_br     = resolve_s & ~legal_s & ~rst;
   assign bus.redirect_pc    = taken_s ? bus.ex_target : bus.ex_pc + 32'd4;
   assign bus.cnt_branches   = cnt_branches_r;
   assign bus.cnt_mispredict = cnt_mispredict_r;

   // Statistics counters: frozen by stall, clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_branches_r   <= 32'd0;
         cnt_mispredict_r <= 32'd0;
      end else if (bus.stall) begin
         cnt_branches_r   <= cnt_branches_r;
         cnt_mispredict_r <= cnt_mispredict_r;
      end else if (bus.cnt_clr) begin
         cnt_branches_r   <= 32'd0;
         cnt_mispredict_r <= 32'd0;
      end else begin
         if (update_s) begin
            cnt_branches_r <= sat_inc32(cnt_branches_r);
         end
         if (update_s & mispredict_s) begin
            cnt_mispredict_r <= sat_inc32(cnt_mispredict_r);
         end
      end
   end
endmodule

// File: tb/tb_branch_unit.sv
// Directed plus randomized bench for branch_unit against a behavioural reference model;
// adapts its expectations to whether BRANCH_PREDICT_EN is defined.
module tb_branch_unit;
   localparam int ENTRIES = 64;
`ifdef BRANCH_PREDICT_EN
   localparam bit PRED_EN = 1'b1;
`else
   localparam bit PRED_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   branch_unit_if bus_i ();

   branch_unit #(.BHT_ENTRIES(ENTRIES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_i)
   );

   always #5 clk = ~clk;

   int     checks   = 0;
   int     failures = 0;
   longint m_br;
   longint m_mp;
   int     m_tab [ENTRIES];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_taken(input bit [2:0] f3, input bit eq, input bit lt);
      bit cond;
      cond = f3[2] ? lt : eq;
      return cond ^ f3[0];
   endfunction

   function automatic bit ref_legal(input bit [2:0] f3);
      return !(f3 == 3'd2 || f3 == 3'd3);
   endfunction

   function automatic int idx_of(input bit [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   task automatic model_reset();
      m_br = 0;
      m_mp = 0;
      for (int i = 0; i < ENTRIES; i++) m_tab[i] = 1;
   endtask

   // One cycle: drive at negedge, check combinational outputs, clock, check counters.
   task automatic step(input string tag, input bit v, input bit isb, input bit [2:0] f3,
                       input bit [31:0] pc, input bit [31:0] tgt, input bit pt,
                       input bit eq, input bit lt, input bit st, input bit clr,
                       input bit iv, input bit [31:0] ipc);
      bit res, leg, tk, e_pred, e_redir;
      int ix;
      bus_i.ex_valid      = v;
      bus_i.ex_is_branch  = isb;
      bus_i.ex_funct3     = f3;
      bus_i.ex_pc         = pc;
      bus_i.ex_target     = tgt;
      bus_i.ex_pred_taken = pt;
      bus_i.br_eq         = eq;
      bus_i.br_lt         = lt;
      bus_i.stall         = st;
      bus_i.cnt_clr       = clr;
      bus_i.if_valid      = iv;
      bus_i.if_pc         = ipc;
      #1;
      res     = v && isb && !st;
      leg     = ref_legal(f3);
      tk      = leg && ref_taken(f3, eq, lt);
      e_pred  = iv && PRED_EN && (m_tab[idx_of(ipc)] >= 2);
      e_redir = res && leg && (PRED_EN ? (tk != pt) : tk);
      chk({tag, ".pred_taken"},  bus_i.pred_taken,  e_pred);
      chk({tag, ".br_un"},       bus_i.br_un,       f3[1]);
      chk({tag, ".redirect"},    bus_i.redirect,    e_redir);
      chk({tag, ".redirect_pc"}, bus_i.redirect_pc, tk ? tgt : pc + 32'd4);
      chk({tag, ".illegal_br"},  bus_i.illegal_br,  res && !leg);
      @(posedge clk);
      if (!st) begin
         if (clr) begin
            m_br = 0;
            m_mp = 0;
         end else begin
            if (res && leg && m_br < 64'hFFFF_FFFF) m_br++;
            if (e_redir && m_mp < 64'hFFFF_FFFF) m_mp++;
         end
         if (res && leg) begin
            ix = idx_of(pc);
            m_tab[ix] = tk ? ((m_tab[ix] == 3) ? 3 : m_tab[ix] + 1)
                           : ((m_tab[ix] == 0) ? 0 : m_tab[ix] - 1);
         end
      end
      @(negedge clk);
      chk({tag, ".cnt_branches"},   bus_i.cnt_branches,   m_br[31:0]);
      chk({tag, ".cnt_mispredict"}, bus_i.cnt_mispredict, m_mp[31:0]);
   endtask

   initial begin
      bit [2:0] rf3;
      rst = 1'b1;
      bus_i.ex_valid      = 1'b1;
      bus_i.ex_is_branch  = 1'b1;
      bus_i.ex_funct3     = 3'b000;
      bus_i.ex_pc         = 32'h0000_0200;
      bus_i.ex_target     = 32'h0000_0100;
      bus_i.ex_pred_taken = 1'b0;
      bus_i.br_eq         = 1'b1;
      bus_i.br_lt         = 1'b0;
      bus_i.stall         = 1'b0;
      bus_i.cnt_clr       = 1'b0;
      bus_i.if_valid      = 1'b1;
      bus_i.if_pc         = 32'h0000_0040;
      model_reset();
      #2;
      chk("rst.redirect",       bus_i.redirect,       32'd0);
      chk("rst.pred_taken",     bus_i.pred_taken,     32'd0);
      chk("rst.cnt_branches",   bus_i.cnt_branches,   32'd0);
      chk("rst.cnt_mispredict", bus_i.cnt_mispredict, 32'd0);
      bus_i.ex_funct3 = 3'b010;
      #1;
      chk("rst.illegal_br", bus_i.illegal_br, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      //    tag           v  isb f3      pc            tgt           pt eq lt st clr iv ipc
      step("beq_mispred", 1, 1, 3'b000, 32'h0000_0200, 32'h0000_0100, 0, 1, 0, 0, 0, 1, 32'h40);
      step("bgeu",        1, 1, 3'b111, 32'h0000_0204, 32'h0000_0300, 1, 0, 0, 0, 0, 1, 32'h80);
      for (int k = 0; k < 3; k++)
         step("bht_taken", 1, 1, 3'b000, 32'h0000_0040, 32'h0000_0500, 1, 1, 0, 0, 0, 1, 32'h40);
      step("bht_lookup",  0, 0, 3'b000, 32'h0,         32'h0,         0, 0, 0, 0, 0, 1, 32'h40);
      step("bht_bypass",  1, 1, 3'b000, 32'h0000_0040, 32'h0000_0500, 1, 0, 0, 0, 0, 1, 32'h40);
      step("illegal",     1, 1, 3'b010, 32'h0000_0040, 32'h0000_0600, 0, 1, 1, 0, 0, 1, 32'h40);
      step("illegal011",  1, 1, 3'b011, 32'h0000_0044, 32'h0000_0600, 1, 0, 1, 0, 0, 1, 32'h44);
      step("pc_wrap",     1, 1, 3'b001, 32'hFFFF_FFFC, 32'h0000_0700, 1, 1, 0, 0, 0, 1, 32'h40);
      step("stall",       1, 1, 3'b000, 32'h0000_0040, 32'h0000_0800, 0, 1, 0, 1, 0, 1, 32'h40);
      step("if_invalid",  0, 1, 3'b100, 32'h0000_0040, 32'h0000_0800, 0, 0, 1, 0, 0, 0, 32'h40);

      for (int n = 0; n < 150; n++) begin
         rf3 = 3'($urandom_range(0, 7));
         step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), rf3,
              32'h40 + 32'($urandom_range(0, 7)) * 32'd4, $urandom, 1'($urandom),
              1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 19) == 0), 1'($urandom),
              32'h40 + 32'($urandom_range(0, 7)) * 32'd4);
      end

      force dut.cnt_branches_r   = 32'hFFFF_FFFF;
      force dut.cnt_mispredict_r = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_branches_r;
      release dut.cnt_mispredict_r;
      m_br = 64'hFFFF_FFFF;
      m_mp = 64'hFFFF_FFFF;
      step("sat",         1, 1, 3'b000, 32'h0000_0048, 32'h0000_0900, 0, 1, 0, 0, 0, 1, 32'h44);
      step("clr_wins",    1, 1, 3'b000, 32'h0000_0048, 32'h0000_0900, 0, 1, 0, 0, 1, 1, 32'h44);
      step("pre_rst",     1, 1, 3'b000, 32'h0000_0040, 32'h0000_0900, 0, 1, 0, 0, 0, 1, 32'h40);
      step("pre_rst2",    1, 1, 3'b000, 32'h0000_0040, 32'h0000_0900, 0, 1, 0, 0, 0, 1, 32'h40);

      #2;
      rst = 1'b1;
      #1;
      chk("midrst.cnt_branches",   bus_i.cnt_branches,   32'd0);
      chk("midrst.cnt_mispredict", bus_i.cnt_mispredict, 32'd0);
      chk("midrst.pred_taken",     bus_i.pred_taken,     32'd0);
      chk("midrst.redirect",       bus_i.redirect,       32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step("post_rst",    0, 0, 3'b000, 32'h0,         32'h0,         0, 0, 0, 0, 0, 1, 32'h40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
